trafficgenr_stream_gen: RTL and testbench

- Traffic-generation engine fed by the trafficgenr AXI4-Lite register bank.
- Takes the latched configuration fields (length, count, gap, seed) plus start/stop strobes from the register bank.
- Emits AXI4-Stream packets with a deterministic payload; returns busy/done/packet-count status for register readback.

---
 rtl/trafficgenr_pkg.sv | 23 ++
 rtl/trafficgenr_payload_gen.sv | 39 +++
 rtl/trafficgenr_stream_gen.sv | 181 ++++++++++++++++++
 tb/tb_trafficgenr_stream_gen.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trafficgenr_pkg.sv
// Shared types and constants for the trafficgenr stream engine.
// The optional LFSR payload is selected with TRAFFICGENR_LFSR_EN.
package trafficgenr_pkg;

    localparam int TG_DATA_WIDTH = 32;
    localparam int TG_LEN_WIDTH  = 16;
    localparam int TG_GAP_WIDTH  = 8;

    localparam logic [31:0] TG_LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } tg_state_t;

    function automatic logic [31:0] tg_lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TG_LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/trafficgenr_payload_gen.sv
// Deterministic 32-bit payload source: counter by default,
// Galois LFSR when TRAFFICGENR_LFSR_EN is defined.
module trafficgenr_payload_gen
    import trafficgenr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_seed,
    input  logic        i_load,
    input  logic        i_advance,
    output logic [31:0] o_data
);

    logic [31:0] r_data;
    logic [31:0] w_init;
    logic [31:0] w_next;

`ifdef TRAFFICGENR_LFSR_EN
    // An all-zero LFSR would lock up, so a zero seed becomes 1
    assign w_init = (i_seed == 32'd0) ? 32'd1 : i_seed;
    assign w_next = tg_lfsr_step(r_data);
`else
    assign w_init = i_seed;
    assign w_next = r_data + 32'd1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data <= 32'd0;
        end else if (i_load) begin
            r_data <= w_init;
        end else if (i_advance) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/trafficgenr_stream_gen.sv
// AXI4-Stream packet generator driven by the trafficgenr register bank.
// Payload mode selected by TRAFFICGENR_LFSR_EN (see payload_gen).
module trafficgenr_stream_gen
    import trafficgenr_pkg::*;
#(
    parameter int DATA_WIDTH = TG_DATA_WIDTH,
    parameter int LEN_WIDTH  = TG_LEN_WIDTH,
    parameter int GAP_WIDTH  = TG_GAP_WIDTH
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [31:0]           cfg_seed,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    output logic                  M_AXIS_TLAST,
    input  logic                  M_AXIS_TREADY,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [LEN_WIDTH-1:0]  sts_pkt_sent
);

    localparam logic [LEN_WIDTH-1:0] L_ONE = 1;
    localparam logic [GAP_WIDTH-1:0] G_ONE = 1;

    tg_state_t r_state;
    tg_state_t w_next_state;

    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_count;
    logic [GAP_WIDTH-1:0] r_gap;
    logic [31:0]          r_seed;
    logic                 r_stop;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [LEN_WIDTH-1:0] r_pkt_sent;
    logic [GAP_WIDTH-1:0] r_gap_cnt;
    logic                 r_tvalid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_hs;
    logic                 w_beat_last;
    logic                 w_pkt_last;
    logic                 w_stop_pend;
    logic                 w_empty_cfg;
    logic                 w_gen_load;
    logic [31:0]          w_payload;

    assign w_hs        = r_tvalid & M_AXIS_TREADY;
    assign w_beat_last = (r_beat == (r_len - L_ONE));
    assign w_pkt_last  = ((r_pkt_sent + L_ONE) == r_count);
    assign w_stop_pend = r_stop | ctrl_stop;
    assign w_empty_cfg = (r_len == '0) | (r_count == '0);
    assign w_gen_load  = (r_state == ST_LOAD) & ~w_empty_cfg;

    trafficgenr_payload_gen u_payload (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETN),
        .i_seed    (r_seed),
        .i_load    (w_gen_load),
        .i_advance (w_hs),
        .o_data    (w_payload)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ctrl_start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_next_state = w_empty_cfg ? ST_FIN : ST_SEND;
            end
            ST_SEND: begin
                if (w_hs && w_beat_last) begin
                    if (w_pkt_last || w_stop_pend) begin
                        w_next_state = ST_FIN;
                    end else if (r_gap != '0) begin
                        w_next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_stop_pend) begin
                    w_next_state = ST_FIN;
                end else if (r_gap_cnt == G_ONE) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // TVALID is registered: it rises one cycle after entering SEND, and
    // the last GAP cycle preloads it so the idle gap is exactly r_gap.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_len      <= '0;
            r_count    <= '0;
            r_gap      <= '0;
            r_seed     <= '0;
            r_stop     <= 1'b0;
            r_beat     <= '0;
            r_pkt_sent <= '0;
            r_gap_cnt  <= '0;
            r_tvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIN);
            unique case (r_state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        r_len      <= cfg_pkt_len;
                        r_count    <= cfg_pkt_count;
                        r_gap      <= cfg_gap;
                        r_seed     <= cfg_seed;
                        r_pkt_sent <= '0;
                        r_busy     <= 1'b1;
                        r_stop     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_beat <= '0;
                    if (ctrl_stop) r_stop <= 1'b1;
                end
                ST_SEND: begin
                    if (ctrl_stop) r_stop <= 1'b1;
                    if (!r_tvalid) begin
                        r_tvalid <= 1'b1;
                    end else if (w_hs) begin
                        if (w_beat_last) begin
                            r_pkt_sent <= r_pkt_sent + L_ONE;
                            r_beat     <= '0;
                            r_gap_cnt  <= r_gap;
                            r_tvalid   <= (w_next_state == ST_SEND);
                        end else begin
                            r_beat <= r_beat + L_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - G_ONE;
                    if (w_next_state == ST_SEND) r_tvalid <= 1'b1;
                end
                ST_FIN: begin
                    r_busy <= 1'b0;
                    r_stop <= 1'b0;
                end
                default: begin
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign M_AXIS_TDATA  = w_payload;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TLAST  = r_tvalid & w_beat_last;
    assign sts_busy      = r_busy;
    assign sts_done      = r_done;
    assign sts_pkt_sent  = r_pkt_sent;

endmodule

// File: tb/tb_trafficgenr_stream_gen.sv
// Scoreboard bench for trafficgenr_stream_gen; payload model follows
// TRAFFICGENR_LFSR_EN so either build can be checked.
module tb_trafficgenr_stream_gen;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        ctrl_start;
    logic        ctrl_stop;
    logic [15:0] cfg_pkt_len;
    logic [15:0] cfg_pkt_count;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_seed;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        sts_busy;
    logic        sts_done;
    logic [15:0] sts_pkt_sent;

    always #5 ACLK = ~ACLK;

    trafficgenr_stream_gen dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .ctrl_start    (ctrl_start),
        .ctrl_stop     (ctrl_stop),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_count (cfg_pkt_count),
        .cfg_gap       (cfg_gap),
        .cfg_seed      (cfg_seed),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_pkt_sent  (sts_pkt_sent)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    int          beats_seen = 0;
    logic        p_stall = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;

    function automatic logic [31:0] mdl_first(input logic [31:0] s);
`ifdef TRAFFICGENR_LFSR_EN
        return (s == 32'd0) ? 32'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] mdl_next(input logic [31:0] v);
`ifdef TRAFFICGENR_LFSR_EN
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
        return v + 32'd1;
`endif
    endfunction

    // Monitor: handshakes are popped against the scoreboard, stalls must hold
    always @(negedge ACLK) begin
        beat_t e;
        if (ARESETN && M_AXIS_TVALID) begin
            if (p_stall) begin
                tests++;
                if (M_AXIS_TDATA !== p_data || M_AXIS_TLAST !== p_last) begin
                    fails++;
                    $display("FAIL stall_hold: got %h/%b need %h/%b",
                             M_AXIS_TDATA, M_AXIS_TLAST, p_data, p_last);
                end
            end
            if (M_AXIS_TREADY) begin
                beats_seen++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: got %h with nothing expected",
                             M_AXIS_TDATA);
                end else begin
                    e = sb.pop_front();
                    if (M_AXIS_TDATA !== e.d || M_AXIS_TLAST !== e.l) begin
                        fails++;
                        $display("FAIL beat: got %h/%b need %h/%b",
                                 M_AXIS_TDATA, M_AXIS_TLAST, e.d, e.l);
                    end
                end
            end
        end
        p_stall = ARESETN && M_AXIS_TVALID && !M_AXIS_TREADY;
        p_data  = M_AXIS_TDATA;
        p_last  = M_AXIS_TLAST;
    end

    task automatic push_run(input int len, input int count,
                            input logic [31:0] seed);
        logic [31:0] v;
        v = mdl_first(seed);
        for (int p = 0; p < count; p++) begin
            for (int b = 0; b < len; b++) begin
                sb.push_back(beat_t'{d: v, l: (b == len - 1)});
                v = mdl_next(v);
            end
        end
    endtask

    task automatic start_run(input int len, input int count, input int gap,
                             input logic [31:0] seed, input bit with_stop);
        @(posedge ACLK); #1;
        cfg_pkt_len   = 16'(len);
        cfg_pkt_count = 16'(count);
        cfg_gap       = 8'(gap);
        cfg_seed      = seed;
        ctrl_start    = 1'b1;
        ctrl_stop     = with_stop;
        @(posedge ACLK); #1;
        ctrl_start    = 1'b0;
        ctrl_stop     = 1'b0;
        cfg_pkt_len   = 16'd1;
        cfg_pkt_count = 16'd1;
        cfg_gap       = 8'd0;
        cfg_seed      = 32'hDEAD_BEEF;
    endtask

    // k counts negedges after the start edge; k=1 is half a cycle after it
    task automatic run_wait(input int budget, input bit stall,
                            input int stop_at, output int k_done,
                            output int k_first, output int low_busy,
                            output int not_busy);
        bit stop_sent;
        stop_sent = 1'b0;
        k_done = -1;
        k_first = -1;
        low_busy = 0;
        not_busy = 0;
        for (int k = 1; k <= budget; k++) begin
            if (stall) M_AXIS_TREADY = ((k % 4) == 1) || ((k % 4) == 0);
            if (stop_at >= 0 && !stop_sent && beats_seen >= stop_at) begin
                ctrl_stop = 1'b1;
                stop_sent = 1'b1;
            end else begin
                ctrl_stop = 1'b0;
            end
            @(negedge ACLK);
            if (M_AXIS_TVALID && k_first < 0) k_first = k;
            if (k_first >= 0 && sts_busy && !M_AXIS_TVALID && sb.size() > 0)
                low_busy++;
            if (!sts_busy && !sts_done) not_busy++;
            if (sts_done) begin
                k_done = k;
                break;
            end
            @(posedge ACLK); #1;
        end
        ctrl_stop = 1'b0;
        M_AXIS_TREADY = 1'b1;
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        cfg_pkt_len = '0;
        cfg_pkt_count = '0;
        cfg_gap = '0;
        cfg_seed = '0;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        tests++;
        if (M_AXIS_TVALID !== 1'b0) begin
            fails++; $display("FAIL rst_tvalid: got %b need 0", M_AXIS_TVALID);
        end
        tests++;
        if (M_AXIS_TLAST !== 1'b0) begin
            fails++; $display("FAIL rst_tlast: got %b need 0", M_AXIS_TLAST);
        end
        tests++;
        if (M_AXIS_TDATA !== 32'd0) begin
            fails++; $display("FAIL rst_tdata: got %h need 0", M_AXIS_TDATA);
        end
        tests++;
        if (sts_busy !== 1'b0 || sts_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_sts: got busy %b done %b need 0 0",
                     sts_busy, sts_done);
        end
        tests++;
        if (sts_pkt_sent !== 16'd0) begin
            fails++; $display("FAIL rst_sent: got %0d need 0", sts_pkt_sent);
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
    endtask

    task automatic test_back_to_back;
        int kd, kf, lb, nb;
        push_run(4, 2, 32'h10);
        start_run(4, 2, 0, 32'h10, 1'b0);
        run_wait(100, 1'b0, -1, kd, kf, lb, nb);
        tests++;
        if (kf != 3) begin
            fails++; $display("FAIL b2b_latency: got k=%0d need 3", kf);
        end
        tests++;
        if (kd != 12) begin
            fails++; $display("FAIL b2b_done_time: got k=%0d need 12", kd);
        end
        tests++;
        if (sts_pkt_sent !== 16'd2 || sts_busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_status: got sent %0d busy %b need 2 0",
                     sts_pkt_sent, sts_busy);
        end
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL b2b_beats: got %0d left need 0", sb.size());
        end
        @(negedge ACLK);
        tests++;
        if (sts_done !== 1'b0) begin
            fails++; $display("FAIL b2b_done_pulse: got %b need 0", sts_done);
        end
    endtask

    task automatic test_gap;
        int kd, kf, lb, nb, b0;
        b0 = beats_seen;
        push_run(3, 3, 32'h20);
        start_run(3, 3, 5, 32'h20, 1'b0);
        run_wait(200, 1'b0, -1, kd, kf, lb, nb);
        tests++;
        if (lb != 10) begin
            fails++; $display("FAIL gap_idle: got %0d need 10", lb);
        end
        tests++;
        if (nb != 0 || kd < 0) begin
            fails++;
            $display("FAIL gap_busy: got %0d idle cycles, done k=%0d need 0", nb, kd);
        end
        tests++;
        if (beats_seen - b0 != 9 || sts_pkt_sent !== 16'd3 || sb.size() != 0) begin
            fails++;
            $display("FAIL gap_total: got %0d beats sent %0d need 9 3",
                     beats_seen - b0, sts_pkt_sent);
        end
    endtask

    task automatic test_stall;
        int kd, kf, lb, nb, b0;
        b0 = beats_seen;
        push_run(4, 1, 32'h10);
        start_run(4, 1, 0, 32'h10, 1'b0);
        run_wait(200, 1'b1, -1, kd, kf, lb, nb);
        tests++;
        if (kd < 0 || beats_seen - b0 != 4 || sb.size() != 0) begin
            fails++;
            $display("FAIL stall_total: got %0d beats done k=%0d need 4",
                     beats_seen - b0, kd);
        end
        tests++;
        if (sts_pkt_sent !== 16'd1) begin
            fails++; $display("FAIL stall_sent: got %0d need 1", sts_pkt_sent);
        end
    endtask

    task automatic test_stop;
        int kd, kf, lb, nb, b0;
        b0 = beats_seen;
        push_run(8, 2, 32'h30);
        start_run(8, 10, 0, 32'h30, 1'b0);
        run_wait(400, 1'b0, b0 + 10, kd, kf, lb, nb);
        tests++;
        if (kd < 0 || sts_pkt_sent !== 16'd2) begin
            fails++;
            $display("FAIL stop_sent: got %0d done k=%0d need 2", sts_pkt_sent, kd);
        end
        tests++;
        if (beats_seen - b0 != 16 || sb.size() != 0) begin
            fails++; $display("FAIL stop_beats: got %0d need 16", beats_seen - b0);
        end
    endtask

    task automatic test_start_stop;
        int kd, kf, lb, nb;
        push_run(2, 2, 32'h40);
        start_run(2, 2, 1, 32'h40, 1'b1);
        run_wait(100, 1'b0, -1, kd, kf, lb, nb);
        tests++;
        if (kd < 0 || sts_pkt_sent !== 16'd2 || sb.size() != 0) begin
            fails++;
            $display("FAIL start_stop: got sent %0d done k=%0d need 2",
                     sts_pkt_sent, kd);
        end
    endtask

    task automatic test_zero;
        int kd, kf, lb, nb;
        for (int i = 0; i < 2; i++) begin
            start_run((i == 0) ? 0 : 4, (i == 0) ? 3 : 0, 0, 32'h50, 1'b0);
            run_wait(50, 1'b0, -1, kd, kf, lb, nb);
            tests++;
            if (kf != -1 || kd != 3) begin
                fails++;
                $display("FAIL zero_cfg%0d: got first valid k=%0d done k=%0d need -1 3",
                         i, kf, kd);
            end
            tests++;
            if (sts_pkt_sent !== 16'd0) begin
                fails++; $display("FAIL zero_sent%0d: got %0d need 0", i, sts_pkt_sent);
            end
        end
    endtask

    task automatic test_reset_midrun;
        int kd, kf, lb, nb, b0;
        bit hit;
        b0 = beats_seen;
        hit = 1'b0;
        push_run(8, 2, 32'h55);
        start_run(8, 2, 0, 32'h55, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (beats_seen - b0 >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL midrun_timeout: got %0d beats need 3", beats_seen - b0);
        end
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        tests++;
        if (M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 ||
            M_AXIS_TDATA !== 32'd0 || sts_busy !== 1'b0 || sts_pkt_sent !== 16'd0) begin
            fails++;
            $display("FAIL midrun_reset: got v%b l%b d%h b%b s%0d need all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, sts_busy, sts_pkt_sent);
        end
        sb.delete();
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        push_run(2, 1, 32'd0);
        start_run(2, 1, 0, 32'd0, 1'b0);
        run_wait(50, 1'b0, -1, kd, kf, lb, nb);
        tests++;
        if (kf != 3 || kd < 0 || sts_pkt_sent !== 16'd1 || sb.size() != 0) begin
            fails++;
            $display("FAIL midrun_restart: got first k=%0d sent %0d left %0d need 3 1 0",
                     kf, sts_pkt_sent, sb.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_back_to_back;
        test_gap;
        test_stall;
        test_stop;
        test_start_stop;
        test_zero;
        test_reset_midrun;
        repeat (2) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
